// File: rtl/sp_ram_arbiter_if.sv
// Request/grant, clear-control and RAM-side signals of the single-port RAM arbiter.
// slave is the arbiter's view; master is the client's and RAM's view.
interface sp_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              ram_ce;
    logic              ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_oce;
    logic              ram_reset;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, ram_dout,
        output wr_ready, rd_ready, rd_valid, rd_data, clr_busy, clr_done,
               ram_ce, ram_wre, ram_ad, ram_din, ram_oce, ram_reset
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, ram_dout,
        input  wr_ready, rd_ready, rd_valid, rd_data, clr_busy, clr_done,
               ram_ce, ram_wre, ram_ad, ram_din, ram_oce, ram_reset
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin write/read arbiter for a single-port RAM in bypass read mode,
// with a one-word-per-cycle zero-fill sweep of the whole array.
module sp_ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sp_ram_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_last_wr;
    logic              r_ram_ce;
    logic              r_ram_wre;
    logic [ADDR_W-1:0] r_ram_ad;
    logic [DATA_W-1:0] r_ram_din;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_rd_pend;
    logic              r_rd_valid;
    logic              r_clr_busy;
    logic              r_clr_done;

    logic              w_grant_ok;
    logic              w_wr_ready;
    logic              w_rd_ready;

    // clr_start suppresses grants in its own cycle so no transfer races the sweep.
    always_comb begin
        w_grant_ok = (r_state == ST_IDLE) && !bus.clr_start;
        w_wr_ready = w_grant_ok && bus.wr_req && (!bus.rd_req || !r_last_wr);
        w_rd_ready = w_grant_ok && bus.rd_req && (!bus.wr_req ||  r_last_wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last_wr  <= 1'b0;
            r_ram_ce   <= 1'b0;
            r_ram_wre  <= 1'b0;
            r_ram_ad   <= '0;
            r_ram_din  <= '0;
            r_clr_addr <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            // Read data returns one cycle after the RAM samples the address.
            r_rd_pend  <= w_rd_ready;
            r_rd_valid <= r_rd_pend;
            r_clr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ram_ce  <= 1'b0;
                    r_ram_wre <= 1'b0;
                    if (bus.clr_start) begin
                        r_state    <= ST_CLEAR;
                        r_clr_busy <= 1'b1;
                        r_clr_addr <= '0;
                    end else if (w_wr_ready) begin
                        r_ram_ce  <= 1'b1;
                        r_ram_wre <= 1'b1;
                        r_ram_ad  <= bus.wr_addr;
                        r_ram_din <= bus.wr_data;
                        r_last_wr <= 1'b1;
                    end else if (w_rd_ready) begin
                        r_ram_ce  <= 1'b1;
                        r_ram_wre <= 1'b0;
                        r_ram_ad  <= bus.rd_addr;
                        r_last_wr <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_ram_ce   <= 1'b1;
                    r_ram_wre  <= 1'b1;
                    r_ram_ad   <= r_clr_addr;
                    r_ram_din  <= '0;
                    r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    if (r_clr_addr == '1) begin
                        r_state    <= ST_IDLE;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_ready  = w_rd_ready;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = bus.ram_dout;
    assign bus.clr_busy  = r_clr_busy;
    assign bus.clr_done  = r_clr_done;
    assign bus.ram_ce    = r_ram_ce;
    assign bus.ram_wre   = r_ram_wre;
    assign bus.ram_ad    = r_ram_ad;
    assign bus.ram_din   = r_ram_din;
    assign bus.ram_oce   = 1'b1;
    assign bus.ram_reset = 1'b0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: vector table for arbitration and RAM timing,
// plus sequences for the zero-fill sweep, bursts and reset behaviour.
module tb_sp_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sp_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Single-port RAM, bypass read: data appears the cycle after the address is sampled.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_ce) begin
            if (bus.ram_wre) mem[bus.ram_ad] <= bus.ram_din;
            else             ram_q <= mem[bus.ram_ad];
        end
    end
    assign bus.ram_dout = ram_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wq;  logic [11:0] wa; logic [15:0] wd;
        logic          rq;  logic [11:0] ra;
        logic          ewr; logic erd; logic ece; logic ewre;
        logic [11:0]   ead; logic [15:0] edin;
        logic          erv; logic [15:0] erdat;
    } vec_t;

    function automatic vec_t mkv(input logic wq, input logic [11:0] wa, input logic [15:0] wd,
                                 input logic rq, input logic [11:0] ra,
                                 input logic ewr, input logic erd, input logic ece, input logic ewre,
                                 input logic [11:0] ead, input logic [15:0] edin,
                                 input logic erv, input logic [15:0] erdat);
        vec_t v;
        v.wq = wq; v.wa = wa; v.wd = wd; v.rq = rq; v.ra = ra;
        v.ewr = ewr; v.erd = erd; v.ece = ece; v.ewre = ewre;
        v.ead = ead; v.edin = edin; v.erv = erv; v.erdat = erdat;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.clr_start = 1'b0;
    endtask

    // Issue n back-to-back reads from address 0; data expected base (+k if incr).
    task automatic read_burst(input int n, input logic [15:0] base, input logic incr, input string tag);
        for (int k = 0; k <= n + 2; k++) begin
            if (k < n) begin
                bus.rd_req = 1'b1; bus.rd_addr = 12'(k);
            end else begin
                bus.rd_req = 1'b0;
            end
            #1;
            if (k < n) chk($sformatf("%s_rd_ready%0d", tag, k), bus.rd_ready, 1'b1);
            chk($sformatf("%s_rv%0d", tag, k), bus.rd_valid, (k >= 2 && k <= n + 1));
            if (k >= 2 && k <= n + 1)
                chk($sformatf("%s_rdata%0d", tag, k - 2), bus.rd_data,
                    incr ? 32'(base + 16'(k - 2)) : 32'(base));
            next_cycle();
        end
    endtask

    vec_t vt [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, sweep_wr, sweep_bad, early, cyc, exp_addr;
        logic got_rdy;

        vt[0]  = mkv(0,12'h000,16'h0000, 0,12'h000, 0,0, 0,0,12'h000,16'h0000, 0,16'h0000);
        vt[1]  = mkv(1,12'h005,16'h1234, 0,12'h000, 1,0, 0,0,12'h000,16'h0000, 0,16'h0000);
        vt[2]  = mkv(0,12'h000,16'h0000, 1,12'h005, 0,1, 1,1,12'h005,16'h1234, 0,16'h0000);
        vt[3]  = mkv(0,12'h000,16'h0000, 0,12'h000, 0,0, 1,0,12'h005,16'h1234, 0,16'h0000);
        vt[4]  = mkv(0,12'h000,16'h0000, 0,12'h000, 0,0, 0,0,12'h005,16'h1234, 1,16'h1234);
        vt[5]  = mkv(1,12'h006,16'hAAAA, 1,12'h005, 1,0, 0,0,12'h005,16'h1234, 0,16'h0000);
        vt[6]  = mkv(1,12'h006,16'hAAAA, 1,12'h005, 0,1, 1,1,12'h006,16'hAAAA, 0,16'h0000);
        vt[7]  = mkv(1,12'h006,16'hAAAA, 1,12'h005, 1,0, 1,0,12'h005,16'hAAAA, 0,16'h0000);
        vt[8]  = mkv(1,12'h006,16'hAAAA, 1,12'h005, 0,1, 1,1,12'h006,16'hAAAA, 1,16'h1234);
        vt[9]  = mkv(0,12'h000,16'h0000, 0,12'h000, 0,0, 1,0,12'h005,16'hAAAA, 0,16'h0000);
        vt[10] = mkv(0,12'h000,16'h0000, 0,12'h000, 0,0, 0,0,12'h005,16'hAAAA, 1,16'h1234);
        vt[11] = mkv(0,12'h000,16'h0000, 1,12'h006, 0,1, 0,0,12'h005,16'hAAAA, 0,16'h0000);
        vt[12] = mkv(0,12'h000,16'h0000, 0,12'h000, 0,0, 1,0,12'h006,16'hAAAA, 0,16'h0000);
        vt[13] = mkv(0,12'h000,16'h0000, 0,12'h000, 0,0, 0,0,12'h006,16'hAAAA, 1,16'hAAAA);

        idle_inputs();
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce", bus.ram_ce, 1'b0);
        chk("rst_wre", bus.ram_wre, 1'b0);
        chk("rst_ad", bus.ram_ad, 12'h000);
        chk("rst_din", bus.ram_din, 16'h0000);
        chk("rst_rv", bus.rd_valid, 1'b0);
        chk("rst_busy", bus.clr_busy, 1'b0);
        chk("rst_done", bus.clr_done, 1'b0);
        chk("oce", bus.ram_oce, 1'b1);
        chk("ram_reset", bus.ram_reset, 1'b0);
        rst_n = 1'b1;
        next_cycle();

        // Arbitration and RAM-port timing table
        for (int i = 0; i < 14; i++) begin
            bus.wr_req = vt[i].wq; bus.wr_addr = vt[i].wa; bus.wr_data = vt[i].wd;
            bus.rd_req = vt[i].rq; bus.rd_addr = vt[i].ra;
            #1;
            chk($sformatf("v%0d_wr_ready", i), bus.wr_ready, vt[i].ewr);
            chk($sformatf("v%0d_rd_ready", i), bus.rd_ready, vt[i].erd);
            chk($sformatf("v%0d_ce", i), bus.ram_ce, vt[i].ece);
            chk($sformatf("v%0d_wre", i), bus.ram_wre, vt[i].ewre);
            chk($sformatf("v%0d_ad", i), bus.ram_ad, vt[i].ead);
            chk($sformatf("v%0d_din", i), bus.ram_din, vt[i].edin);
            chk($sformatf("v%0d_rv", i), bus.rd_valid, vt[i].erv);
            if (vt[i].erv) chk($sformatf("v%0d_rdata", i), bus.rd_data, vt[i].erdat);
            next_cycle();
        end
        idle_inputs();

        // Fill 0..7 with 0xFFFF
        for (int k = 0; k < 8; k++) begin
            bus.wr_req = 1'b1; bus.wr_addr = 12'(k); bus.wr_data = 16'hFFFF;
            #1;
            chk($sformatf("fill_wr_ready%0d", k), bus.wr_ready, 1'b1);
            next_cycle();
        end
        bus.wr_req = 1'b0;

        // Read of address 2 still in flight when the sweep starts
        bus.rd_req = 1'b1; bus.rd_addr = 12'h002;
        #1;
        chk("pre_clr_rd_ready", bus.rd_ready, 1'b1);
        next_cycle();
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b1; bus.wr_addr = 12'h007; bus.wr_data = 16'h5555;
        bus.clr_start = 1'b1;
        #1;
        chk("clr_start_wr_ready", bus.wr_ready, 1'b0);
        next_cycle();
        bus.clr_start = 1'b0; bus.wr_req = 1'b0;
        chk("clr_pending_rv", bus.rd_valid, 1'b1);
        chk("clr_pending_rdata", bus.rd_data, 16'hFFFF);
        chk("clr_busy_first", bus.clr_busy, 1'b1);

        busy_cnt = 1; done_cnt = 0; sweep_wr = 0; sweep_bad = 0; early = 0; exp_addr = 0;
        got_rdy = 1'b0; cyc = 0;
        while (cyc < 5000 && !got_rdy) begin
            next_cycle();
            cyc++;
            if (bus.ram_ce && bus.ram_wre) begin
                if (bus.ram_ad !== 12'(exp_addr) || bus.ram_din !== 16'h0000) sweep_bad++;
                exp_addr++;
                sweep_wr++;
            end
            if (bus.clr_busy) busy_cnt++;
            if (bus.clr_done) done_cnt++;
            bus.clr_start = (cyc == 10);
            if (cyc == 5) begin bus.rd_req = 1'b1; bus.rd_addr = 12'h003; end
            #1;
            if (bus.rd_ready) begin
                got_rdy = 1'b1;
                if (!bus.clr_done || bus.clr_busy) early++;
            end
        end
        bus.clr_start = 1'b0;
        chk("clr_stall_grant_seen", got_rdy, 1'b1);
        chk("clr_rd_ready_early", early, 0);
        chk("clr_busy_cycles", busy_cnt, 4096);
        chk("clr_done_pulses", done_cnt, 1);
        chk("clr_sweep_writes", sweep_wr, 4096);
        chk("clr_sweep_bad", sweep_bad, 0);
        next_cycle();
        bus.rd_req = 1'b0;
        chk("stalled_rd_ce", bus.ram_ce, 1'b1);
        chk("stalled_rd_wre", bus.ram_wre, 1'b0);
        chk("stalled_rd_ad", bus.ram_ad, 12'h003);
        chk("done_once", bus.clr_done, 1'b0);
        next_cycle();
        chk("stalled_rd_rv", bus.rd_valid, 1'b1);
        chk("stalled_rd_rdata", bus.rd_data, 16'h0000);
        next_cycle();

        read_burst(8, 16'h0000, 1'b0, "zero");

        // Distinct data at 0..15, then a sustained read burst
        for (int k = 0; k < 16; k++) begin
            bus.wr_req = 1'b1; bus.wr_addr = 12'(k); bus.wr_data = 16'h0100 + 16'(k);
            next_cycle();
        end
        bus.wr_req = 1'b0;
        read_burst(16, 16'h0100, 1'b1, "burst");

        // Reset with a read in flight discards its rd_valid
        bus.rd_req = 1'b1; bus.rd_addr = 12'h001;
        #1;
        chk("rst_rd_ready", bus.rd_ready, 1'b1);
        next_cycle();
        bus.rd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ce", bus.ram_ce, 1'b0);
        chk("arst_ad", bus.ram_ad, 12'h000);
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rst_discard_rv%0d", k), bus.rd_valid, 1'b0);
            next_cycle();
        end

        // Pointer back to "last = read": write wins contention
        bus.wr_req = 1'b1; bus.wr_addr = 12'h009; bus.wr_data = 16'h9999;
        bus.rd_req = 1'b1; bus.rd_addr = 12'h001;
        #1;
        chk("rr_after_rst_wr", bus.wr_ready, 1'b1);
        chk("rr_after_rst_rd", bus.rd_ready, 1'b0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Reset 100 cycles into a sweep
        bus.clr_start = 1'b1;
        next_cycle();
        bus.clr_start = 1'b0;
        repeat (100) next_cycle();
        chk("mid_clr_busy", bus.clr_busy, 1'b1);
        chk("mid_clr_wre", bus.ram_wre, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.clr_busy, 1'b0);
        chk("abort_done", bus.clr_done, 1'b0);
        chk("abort_ce", bus.ram_ce, 1'b0);
        chk("abort_wre", bus.ram_wre, 1'b0);
        chk("abort_ad", bus.ram_ad, 12'h000);
        chk("abort_din", bus.ram_din, 16'h0000);
        chk("abort_rv", bus.rd_valid, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 4200; k++) begin
            next_cycle();
            if (bus.clr_done) done_cnt++;
            if (bus.clr_busy) busy_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_busy", busy_cnt, 0);
        bus.wr_req = 1'b1; bus.wr_addr = 12'h00A; bus.wr_data = 16'h0;
        #1;
        chk("abort_idle_grant", bus.wr_ready, 1'b1);
        next_cycle();
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
